// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3,
// one input bit per clock. Results are held stable between conversions so a
// display multiplexer never sees intermediate digits. Inputs above the
// largest representable value saturate to all nines and raise o_overflow.
module bin2bcd_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [BIN_WIDTH-1:0]  i_bin,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DIGITS*4-1:0]   o_bcd_data,
  output logic                  o_done,
  output logic                  o_overflow
);

  // Bits needed to hold the value v-1, i.e. ceil(log2(v)).
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int          BCD_W   = DIGITS * 4;
  localparam int          CNT_W   = clogb2(BIN_WIDTH + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_WIDTH - 1);

  // Every digit >= 5 gets +3 so the following left shift carries correctly
  // into the next decimal digit; the add stays within the 4-bit nibble.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int d = 0; d < DIGITS; d++) begin
      if (b[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Saturated display value for out-of-range inputs: every digit shows 9.
  function automatic logic [BCD_W-1:0] sat_nines();
    return {DIGITS{4'h9}};
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic [BCD_W-1:0]     scratch_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_W-1:0]     data_q, data_d;
  logic                 ovf_out_q, ovf_out_d;
  logic                 done_q, done_d;

  // Next-state and datapath: accept in IDLE, one shift per CONVERT cycle,
  // publish the result for a single cycle in DONE.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    data_d      = data_q;
    ovf_out_d   = ovf_out_q;
    done_d      = 1'b0;
    scratch_adj = add3_digits(scratch_q);
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          shift_d   = i_bin;
          scratch_d = '0;
          cnt_d     = '0;
          ovf_d     = (32'(i_bin) > MAX_VAL);
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        // Bits leaving the top digit are dropped; overflow is already known.
        scratch_d = {scratch_adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
        shift_d   = {shift_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        data_d    = ovf_q ? sat_nines() : scratch_q;
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; asynchronous active-low reset clears all.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      ovf_out_q <= ovf_out_d;
      done_q    <= done_d;
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_bcd_data = data_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: an input monitor pushes reference results into a
// scoreboard queue whenever a request is accepted; an output monitor checks
// o_ready, o_done timing, result values and display stability every cycle.
module tb_bin2bcd_seq;

  localparam int BW   = 14;
  localparam int DG   = 4;
  localparam int MAXV = 9999;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] i_bin = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DG*4-1:0] o_bcd_data;
  logic          o_done;
  logic          o_overflow;

  bin2bcd_seq #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_bin      (i_bin),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_bcd_data (o_bcd_data),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DG*4-1:0] data;
    logic            ovf;
    int              acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   busy = 0;
  bit   hold_mode = 0;
  bit   prev_acc_ok = 0;
  int   prev_acc = 0;
  int   done_cnt = 0;
  int   accept_cnt = 0;
  logic [DG*4-1:0] held_data = '0;
  logic            held_ovf = 1'b0;

  // Reference: plain decimal digit extraction, saturating above MAXV.
  function automatic logic [DG*4-1:0] ref_bcd(input int v);
    logic [DG*4-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < DG; d++) begin
      r[d*4 +: 4] = (v > MAXV) ? 4'd9 : 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output and input monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    bit exp_rdy, exp_done;
    if (!rst_n) begin
      check("rst_ready", 64'(o_ready), 64'd1);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_data", 64'(o_bcd_data), 64'd0);
      check("rst_ovf", 64'(o_overflow), 64'd0);
      q.delete();
      busy = 0;
      prev_acc_ok = 0;
      held_data = '0;
      held_ovf = 1'b0;
    end else begin
      exp_rdy = !(busy && cyc >= acc_cyc && cyc <= acc_cyc + BW);
      check("ready", 64'(o_ready), 64'(exp_rdy));
      exp_done = (q.size() > 0) && (cyc == q[0].acc + BW + 1);
      check("done", 64'(o_done), 64'(exp_done));
      if (o_done) done_cnt++;
      if (o_done && exp_done) begin
        e = q.pop_front();
        check("result", 64'(o_bcd_data), 64'(e.data));
        check("overflow", 64'(o_overflow), 64'(e.ovf));
        held_data = o_bcd_data;
        held_ovf  = o_overflow;
      end else if (!o_done) begin
        check("stable_data", 64'(o_bcd_data), 64'(held_data));
        check("stable_ovf", 64'(o_overflow), 64'(held_ovf));
      end else begin
        held_data = o_bcd_data;
        held_ovf  = o_overflow;
      end
      if (i_valid && o_ready) begin
        e.data = ref_bcd(int'(i_bin));
        e.ovf  = (int'(i_bin) > MAXV);
        e.acc  = cyc + 1;
        q.push_back(e);
        busy = 1;
        acc_cyc = cyc + 1;
        accept_cnt++;
        if (hold_mode && prev_acc_ok)
          check("accept_spacing", 64'(e.acc - prev_acc), 64'(BW + 2));
        prev_acc = e.acc;
        prev_acc_ok = hold_mode;
      end
    end
  end

  // Issue one request and return right after the accept edge.
  task automatic send(input int v);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) check("ready_timeout", 64'd0, 64'd1);
    i_valid = 1'b1;
    i_bin   = BW'(v);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_bin   = BW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int dc;
  int ac;
  int vals[$];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic conversion and latency
    send(1234);
    wait_idle();

    // Assorted in-range values, then overflow and recovery
    vals = '{0, 9999, 5, 8000, 10000, 16383, 42, 10, 99, 1000};
    foreach (vals[i]) begin
      send(vals[i]);
      wait_idle();
    end

    // Request while busy must be ignored
    dc = done_cnt;
    send(1234);
    repeat (3) @(posedge clk);
    #1 i_valid = 1'b1; i_bin = BW'(77);
    @(posedge clk); #1 i_valid = 1'b0;
    wait_idle();
    check("busy_done_count", 64'(done_cnt - dc), 64'd1);

    // Reset in the middle of a conversion
    dc = done_cnt;
    send(4321);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (BW + 4) @(posedge clk);
    #1;
    check("reset_no_done", 64'(done_cnt - dc), 64'd0);
    send(4321);
    wait_idle();

    // Valid held high with random values
    ac = accept_cnt;
    hold_mode = 1;
    i_valid = 1'b1;
    for (int k = 0; k < 1000 * (BW + 2); k++) begin
      i_bin = ($urandom_range(0, 7) == 0) ? BW'($urandom_range(9990, 10010)) : BW'($urandom);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    hold_mode = 0;
    wait_idle();
    check("hold_accepts", 64'(accept_cnt - ac), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
